seq_divider_8: RTL and testbench
================================

SEQ_DIVIDER_8 -- requirements
Module: seq_divider_8

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port: a  input  8  unsigned dividend; captured with start.
REQ-005 SHALL have port: b  input  8  unsigned divisor; captured with start.
REQ-006 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-007 SHALL have port: done  output  1  registered; high for exactly one cycle when a result becomes valid.
REQ-008 SHALL have port: q  output  8  registered quotient.
REQ-009 SHALL have port: r  output  8  registered remainder.
REQ-010 SHALL have port: dz  output  1  registered divide-by-zero flag.

Function
REQ-011 SHALL implement the states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 at edge E0: capture a and b, clear the 9-bit partial remainder, load iteration count 0, and enter RUN.
REQ-013 SHALL perform one restoring-division step per RUN cycle: shift {rem, dividend MSB} left, trial = rem - {0,b} in 9 bits, and on no borrow keep trial and set q bit=1, else restore and set q bit=0.
REQ-014 SHALL execute exactly 8 RUN steps; after the 8th step, enter DONE, load q and r, and assert done so it is high from edge E9 to edge E10.
REQ-015 SHALL return from DONE to IDLE unconditionally, so the earliest next start is sampled at E10.
REQ-016 SHALL ignore start while busy=1; captured operands SHALL NOT change mid-operation.
REQ-017 SHALL ignore changes on a and b after E0.
REQ-018 SHALL hold q, r and dz at their last result values until the next done.
REQ-019 SHALL guarantee q*b + r = a and r < b for every b != 0.
REQ-020 SHALL produce q=0, r=a when a < b.

Reset
REQ-021 SHALL, on rst_n=0 at any time, force IDLE immediately and clear to 0 busy, done, q, r, dz, count and the internal registers.
REQ-022 SHALL abort any in-flight division on reset with no done pulse; after release the first start SHALL behave as from cold.

Configuration
REQ-023 SHALL support the macro DIV_ZERO_CHECK_EN.
REQ-024 SHALL, when DIV_ZERO_CHECK_EN is defined and b=0 at E0, go directly IDLE->DONE, set q=8'hFF, r=a, dz=1, and assert done from E1 to E2.
REQ-025 SHALL, when DIV_ZERO_CHECK_EN is defined and b!=0, set dz=0 with each result.
REQ-026 SHALL, when DIV_ZERO_CHECK_EN is undefined: tie dz to 0, run b=0 through the normal 8 steps, and produce q=8'hFF, r=a with done at E9.

Verification
REQ-027 SHALL cover: a=100, b=7, start at E0 -> busy=1 from E0, done=1 only in the E9 cycle, q=14, r=2.
REQ-028 SHALL cover: a=255, b=1 -> q=255, r=0 at E9; and a=5, b=9 -> q=0, r=5 at E9.
REQ-029 SHALL cover: a=200, b=0 -> with DIV_ZERO_CHECK_EN: done at E1, q=8'hFF, r=200, dz=1; without the macro: done at E9, q=8'hFF, r=200, dz=0.
REQ-030 SHALL cover: start held high continuously with a=50, b=5 -> results q=10, r=0 at E9; second acceptance at E10; done pulses exactly one cycle each time.
REQ-031 SHALL cover: start (a=77, b=3) at E0, then rst_n=0 at E4 -> immediate IDLE, all outputs 0, no done; new start (a=9, b=2) after release -> q=4, r=1 nine edges later.
REQ-032 SHALL cover: a and b toggled during RUN, start pulsed during RUN -> result matches the operands captured at E0 with no restart.

Source files
------------

// File: rtl/seq_divider_8.sv
// seq_divider_8: 8-bit unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst_n (async, active-low), start, a (dividend), b (divisor) in;
//   busy, done (1-cycle pulse), q (quotient), r (remainder), dz (div-by-zero) out.
// Optional macro DIV_ZERO_CHECK_EN: b=0 skips the 8 steps and raises dz.
module seq_divider_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_rem;
  logic [7:0] r_dvd;
  logic [7:0] r_div;
  logic [2:0] r_cnt;
  logic       r_done;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic [8:0] w_sh;
  logic [9:0] w_sub;
  logic       w_borrow;
  logic       w_zero;

`ifdef DIV_ZERO_CHECK_EN
  logic r_dz;
  assign w_zero = (b == 8'd0);
  assign dz     = r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz <= 1'b0;
    end else if (r_state == DONE) begin
      r_dz <= (r_div == 8'd0);
    end
  end
`else
  assign w_zero = 1'b0;
  assign dz     = 1'b0;
`endif

  // r_dvd shifts the dividend out of its MSB while quotient
  // bits enter at the LSB; after 8 steps it holds the quotient.
  assign w_sh     = {r_rem[7:0], r_dvd[7]};
  assign w_sub    = {r_rem, r_dvd[7]} - {2'b00, r_div};
  assign w_borrow = w_sub[9];

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == 3'd7) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_div <= b;
            r_cnt <= '0;
            if (w_zero) begin
              r_rem <= {1'b0, a};
              r_dvd <= 8'hFF;
            end else begin
              r_rem <= '0;
              r_dvd <= a;
            end
          end
        end
        RUN: begin
          r_rem <= w_borrow ? w_sh : w_sub[8:0];
          r_dvd <= {r_dvd[6:0], ~w_borrow};
          r_cnt <= r_cnt + 3'd1;
        end
        DONE: begin
          r_q    <= r_dvd;
          r_r    <= r_rem[7:0];
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8.sv
// tb_seq_divider_8: directed bench for seq_divider_8 with an
// expected-result queue filled at launch and drained at each done.
module tb_seq_divider_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_divider_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    if (bv == 8'd0) begin
      e.q = 8'hFF;
      e.r = av;
`ifdef DIV_ZERO_CHECK_EN
      e.dz  = 1'b1;
      e.lat = 1;
`else
      e.dz  = 1'b0;
      e.lat = 9;
`endif
    end else begin
      e.q   = av / bv;
      e.r   = av % bv;
      e.dz  = 1'b0;
      e.lat = 9;
    end
    return e;
  endfunction

  // Compare the head of the queue against the DUT once done is seen.
  task automatic retire(input string tag, input int k);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, k, e.lat);
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_dz"}, dz, e.dz);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
    end
  endtask

  // Launch one division; edge E0 is the first posedge after start rises.
  task automatic do_op(input string tag, input logic [7:0] av,
                       input logic [7:0] bv, input bit mess);
    int k;
    logic [7:0] hq;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    sb.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_e0"}, busy, 1'b1);
    k = 1;
    while (!done && k < 40) begin
      if (mess) begin
        a = 8'($urandom);
        b = 8'($urandom);
        start = k[0];
      end
      @(negedge clk);
      if (!done) k++;
    end
    start = 1'b0;
    retire(tag, k);
    hq = q;
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 1'b0);
    @(negedge clk);
    chk({tag, "_hold_q"}, q, hq);
  endtask

  initial begin
    int k;
    int n_done;
    int first_k;
    int second_k;
    logic [7:0] ra;
    logic [7:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", q, 8'd0);
    chk("rst_r", r, 8'd0);
    chk("rst_dz", dz, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("d100_7", 8'd100, 8'd7, 1'b0);
    do_op("d255_1", 8'd255, 8'd1, 1'b0);
    do_op("d5_9", 8'd5, 8'd9, 1'b0);
    do_op("d200_0", 8'd200, 8'd0, 1'b0);
    do_op("d255_255", 8'd255, 8'd255, 1'b0);
    do_op("d254_255", 8'd254, 8'd255, 1'b0);
    do_op("d0_3", 8'd0, 8'd3, 1'b0);
    do_op("mess123_10", 8'd123, 8'd10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(1, 255));
      do_op("rand", ra, rb, 1'b0);
    end

    // start held high: back-to-back acceptance at E0 and E10
    @(negedge clk);
    a = 8'd50;
    b = 8'd5;
    start = 1'b1;
    sb.push_back(model(8'd50, 8'd5));
    sb.push_back(model(8'd50, 8'd5));
    n_done = 0;
    first_k = 0;
    second_k = 0;
    for (int e = 0; e < 24; e++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_k = e;
          retire("held1", 9);
        end else if (n_done == 2) begin
          second_k = e;
          retire("held2", 9);
        end
      end
    end
    start = 1'b0;
    chk("held_first_e9", first_k, 9);
    chk("held_second_e19", second_k, 19);
    chk("held_ndone", n_done, 2);
    repeat (12) @(negedge clk);

    // reset mid-operation: q/r hold 10/0 from the last result
    @(negedge clk);
    a = 8'd77;
    b = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", q, 8'd0);
    chk("abort_r", r, 8'd0);
    chk("abort_dz", dz, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    do_op("d9_2", 8'd9, 8'd2, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
